mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency backing memory between the instruction-fetch requester (stage 1) and the data-access requester (stage 4).
- Arbitrates between them, sequences each transfer over a req/ack handshake to the memory, and returns read data with a one-cycle ready pulse.
- The pipeline stalls on the requester's pending-not-ready status.
- Includes a fetch-starvation guard and a response timeout.

Parameters:
MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is pending before fetch is forced a grant (>=1)
TIMEOUT, 255, WAIT cycles without mem_ack_i before the transfer is aborted (>=1, fits 8 bits)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
if_req_i  in  1  fetch request; held with if_addr_i stable until if_ready_o
if_addr_i  in  32  fetch address
if_ready_o  out  1  one-cycle pulse: fetch complete, if_rdata_o valid
if_rdata_o  out  32  fetched instruction (registered)
dm_req_i  in  1  data request; held with its fields stable until dm_ready_o
dm_we_i  in  1  1 = write, 0 = read
dm_addr_i  in  32  data address
dm_wdata_i  in  32  write data
dm_width_i  in  2  access width code, passed through unchanged
dm_ready_o  out  1  one-cycle pulse: data access complete
dm_rdata_o  out  32  read data (registered)
mem_req_o  out  1  memory request, high throughout WAIT
mem_we_o  out  1  latched write enable (forced 0 for fetch)
mem_addr_o  out  32  latched address
mem_wdata_o  out  32  latched write data
mem_width_o  out  2  latched width (2'b10 = word for fetch)
mem_ack_i  in  1  memory completion, single-cycle, valid only while mem_req_o=1
mem_rdata_i  in  32  read data, valid with mem_ack_i
err_o  out  1  sticky timeout flag

Behaviour:
Reset (rst_i low, asynchronous):
- State IDLE; all outputs 0; streak counter 0; timeout counter 0.

States: IDLE, WAIT, DONE.

IDLE:
- If neither request is high, stay in IDLE.
- Otherwise select the owner:
  - only one request high: that requester;
  - both high: data, unless streak == MAX_DATA_STREAK, in which case fetch.
- At the clock edge, latch the owner's fields into the mem_* registers, set mem_req_o=1, clear the timeout counter, go to WAIT.
- Streak counter update on each grant:
  - data grant with if_req_i high: increment, saturating at MAX_DATA_STREAK;
  - fetch grant: clear;
  - data grant with if_req_i low: clear.

WAIT:
- mem_* outputs are held constant.
- mem_ack_i=1:
  - deassert mem_req_o at the edge;
  - fetch owner: if_rdata_o <= mem_rdata_i;
  - data read: dm_rdata_o <= mem_rdata_i;
  - data write: dm_rdata_o unchanged;
  - assert the owner's ready for the next cycle; go to DONE.
- No ack: increment the timeout counter. When the counter reaches TIMEOUT-1 with no ack:
  - set err_o=1 (sticky);
  - owner's rdata <= 32'h0000_0013 for fetch (NOP), 32'h0 for data;
  - owner's ready asserted next cycle; mem_req_o deasserted; go to DONE.
  - An ack arriving in that same cycle takes precedence over the timeout.

DONE:
- Exactly one of if_ready_o / dm_ready_o is high, for exactly one cycle.
- No arbitration is performed in this cycle, because the old request may still be high.
- Next state: IDLE.
- Ready outputs are 0 in every other state.

Timing:
- Latency from request sampled in IDLE to ready = 2 + (ack delay in WAIT cycles); minimum 2.
- Back-to-back throughput: one transfer per 3 cycles minimum.

Request changes:
- A requester dropping its req while it owns the port does not cancel the transfer; completion still pulses ready.
- A request arriving during WAIT or DONE waits for IDLE.

Reset mid-transfer:
- Reset in WAIT abandons the transfer immediately: mem_req_o drops asynchronously and no ready is pulsed.

Test Plan:
- Fetch only: if_req_i=1, if_addr_i=0x100, ack 1 cycle after mem_req_o rises with rdata 0x00500093 -> mem_addr_o=0x100, mem_we_o=0, mem_width_o=2'b10; if_ready_o single pulse 3 cycles after the sampling edge; if_rdata_o=0x00500093.
- Simultaneous: if_req_i=dm_req_i=1, dm write to 0x40 with data 0xCAFEF00D -> data served first (mem_we_o=1, mem_wdata_o=0xCAFEF00D); fetch served next; dm_rdata_o unchanged.
- Starvation guard: MAX_DATA_STREAK=4, dm_req_i and if_req_i held high -> grant order D,D,D,D,F,D,D,D,D,F; streak resets after the fetch grant.
- Timeout: TIMEOUT=8, dm read, mem_ack_i never asserted -> after 8 WAIT cycles dm_ready_o pulses, dm_rdata_o=0, err_o=1 and stays 1 through later successful transfers until rst_i low.
- Ack on the final timeout cycle: ack with rdata 0x1234 in WAIT cycle 8 -> normal completion, dm_rdata_o=0x1234, err_o stays 0.
- Reset in WAIT: pull rst_i low mid-transfer -> mem_req_o, ready and err outputs are 0 immediately, with no ready pulse after release; the next request proceeds normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// Fetch is forced a grant after MAX_DATA_STREAK consecutive data grants; stalled transfers abort after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ready_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [1:0]  dm_width_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [1:0]  mem_width_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  // state | meaning
  // IDLE  | no transfer; arbitrate and latch the owner's fields
  // WAIT  | mem_req_o high, waiting for mem_ack_i or timeout
  // DONE  | owner's ready pulses; no arbitration (old request may still be high)
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_streak;
  logic [7:0]    r_tmo;
  logic          r_own_fetch;
  logic          w_grant;
  logic          w_grant_fetch;
  logic          w_ack_done;
  logic          w_tmo_done;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    w_grant_fetch = 1'b0;
    w_ack_done    = 1'b0;
    w_tmo_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (if_req_i || dm_req_i) begin
          w_grant       = 1'b1;
          w_grant_fetch = if_req_i && (!dm_req_i || (r_streak == STREAK_MAX));
          w_state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // an ack in the last allowed cycle wins over the timeout
        if (mem_ack_i) begin
          w_ack_done  = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_tmo == TMO_LAST) begin
          w_tmo_done  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      mem_width_o <= 2'b00;
      r_own_fetch <= 1'b0;
      r_streak    <= '0;
      r_tmo       <= 8'h0;
      if_ready_o  <= 1'b0;
      dm_ready_o  <= 1'b0;
      if_rdata_o  <= 32'h0;
      dm_rdata_o  <= 32'h0;
      err_o       <= 1'b0;
    end else begin
      if_ready_o <= (w_ack_done || w_tmo_done) && r_own_fetch;
      dm_ready_o <= (w_ack_done || w_tmo_done) && !r_own_fetch;
      if (w_grant) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= w_grant_fetch ? 1'b0 : dm_we_i;
        mem_addr_o  <= w_grant_fetch ? if_addr_i : dm_addr_i;
        mem_wdata_o <= w_grant_fetch ? 32'h0 : dm_wdata_i;
        mem_width_o <= w_grant_fetch ? 2'b10 : dm_width_i;
        r_own_fetch <= w_grant_fetch;
        r_tmo       <= 8'h0;
        if (!w_grant_fetch && if_req_i)
          r_streak <= (r_streak == STREAK_MAX) ? r_streak : r_streak + 1'b1;
        else
          r_streak <= '0;
      end
      if (w_ack_done) begin
        mem_req_o <= 1'b0;
        if (r_own_fetch)    if_rdata_o <= mem_rdata_i;
        else if (!mem_we_o) dm_rdata_o <= mem_rdata_i;
      end else if (w_tmo_done) begin
        mem_req_o <= 1'b0;
        err_o     <= 1'b1;
        // fetch gets a NOP so the pipeline keeps executing something harmless
        if (r_own_fetch) if_rdata_o <= 32'h0000_0013;
        else             dm_rdata_o <= 32'h0;
      end else if (r_state == ST_WAIT) begin
        r_tmo <= r_tmo + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, data, starvation guard, timeout and mid-transfer reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [1:0]  dm_width;
  logic        if_ready, dm_ready, mem_req, mem_we, err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_width;

  int          total = 0;
  int          bad = 0;
  logic        ack_en = 1'b1;
  int          ack_delay = 0;
  logic [31:0] ack_data = 32'h0;
  logic        grant_q[$];

  mem_port_arbiter #(.MAX_DATA_STREAK(4), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_width_i(dm_width), .dm_ready_o(dm_ready), .dm_rdata_o(dm_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_width_o(mem_width), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .err_o(err)
  );

  always #5 clk = ~clk;

  // memory responder: acks ack_delay cycles into WAIT, logs each grant (1 = fetch address)
  initial begin : mem_model
    int w;
    w = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (w == 0) grant_q.push_back(mem_addr == 32'h100 || mem_addr == 32'h104);
        if (ack_en && w == ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = ack_data;
        end else begin
          mem_ack = 1'b0;
        end
        w++;
      end else begin
        mem_ack = 1'b0;
        w = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // n counts edges from the sampling edge up to the edge that raises ready
  task automatic wait_rdy(output int n, output logic was_if);
    n = 0;
    was_if = 1'b0;
    while (n < 40) begin
      tick();
      n++;
      if (if_ready || dm_ready) begin
        was_if = if_ready;
        return;
      end
    end
    n = 99;
  endtask

  initial begin
    int   n;
    logic wi;
    logic seen;

    rst_n = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_width = 0;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ready", 32'({if_ready, dm_ready}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // fetch only, ack one cycle into WAIT
    if_addr = 32'h100; if_req = 1;
    ack_en = 1; ack_delay = 1; ack_data = 32'h0050_0093;
    wait_rdy(n, wi);
    chk("f_latency", 32'(n), 32'd3);
    chk("f_owner", 32'(wi), 32'd1);
    chk("f_rdata", if_rdata, 32'h0050_0093);
    chk("f_addr", mem_addr, 32'h100);
    chk("f_we", 32'(mem_we), 32'd0);
    chk("f_width", 32'(mem_width), 32'd2);
    chk("f_req_drop", 32'(mem_req), 32'd0);
    if_req = 0;
    tick();
    chk("f_pulse_once", 32'(if_ready), 32'd0);

    // data read, minimum latency
    dm_req = 1; dm_we = 0; dm_addr = 32'h44; dm_width = 2'b10;
    ack_delay = 0; ack_data = 32'h1111_2222;
    wait_rdy(n, wi);
    chk("d_latency", 32'(n), 32'd2);
    chk("d_owner", 32'(wi), 32'd0);
    chk("d_rdata", dm_rdata, 32'h1111_2222);
    dm_req = 0;
    tick();

    // simultaneous: data write first, then fetch
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hCAFE_F00D; dm_width = 2'b01;
    if_req = 1; if_addr = 32'h100; ack_data = 32'hDEAD_BEEF;
    wait_rdy(n, wi);
    chk("s_first_owner", 32'(wi), 32'd0);
    chk("s_we", 32'(mem_we), 32'd1);
    chk("s_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("s_addr", mem_addr, 32'h40);
    chk("s_width", 32'(mem_width), 32'd1);
    chk("s_dm_rdata_kept", dm_rdata, 32'h1111_2222);
    dm_req = 0; ack_data = 32'h00A0_0113;
    wait_rdy(n, wi);
    chk("s_second_owner", 32'(wi), 32'd1);
    chk("s_throughput", 32'(n), 32'd3);
    chk("s_if_rdata", if_rdata, 32'h00A0_0113);
    if_req = 0;
    tick();

    // starvation guard: both held, expect D,D,D,D,F,D,D,D,D,F
    grant_q.delete();
    dm_req = 1; dm_we = 1; dm_addr = 32'h48; if_req = 1;
    n = 0;
    while (grant_q.size() < 10 && n < 200) begin
      tick();
      n++;
    end
    dm_req = 0; if_req = 0;
    repeat (5) tick();
    chk("g_count", 32'(grant_q.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < grant_q.size()) chk($sformatf("g_order%0d", i), 32'(grant_q[i]), 32'((i % 5) == 4));
    chk("g_err_clear", 32'(err), 32'd0);

    // data read timeout
    dm_req = 1; dm_we = 0; dm_addr = 32'h80; dm_width = 2'b10; ack_en = 0;
    wait_rdy(n, wi);
    chk("t_latency", 32'(n), 32'd9);
    chk("t_owner", 32'(wi), 32'd0);
    chk("t_rdata", dm_rdata, 32'h0);
    chk("t_err", 32'(err), 32'd1);
    chk("t_req_drop", 32'(mem_req), 32'd0);
    dm_req = 0;
    tick();
    if_req = 1; if_addr = 32'h104;
    wait_rdy(n, wi);
    chk("t_f_latency", 32'(n), 32'd9);
    chk("t_f_nop", if_rdata, 32'h0000_0013);
    if_req = 0;
    tick();
    ack_en = 1; ack_delay = 0; ack_data = 32'h0010_0073;
    if_req = 1; if_addr = 32'h100;
    wait_rdy(n, wi);
    chk("t_ok_rdata", if_rdata, 32'h0010_0073);
    chk("t_err_sticky", 32'(err), 32'd1);
    if_req = 0;
    tick();

    // reset in WAIT
    dm_req = 1; dm_we = 0; dm_addr = 32'h84; ack_en = 0;
    tick(); tick(); tick();
    chk("r_in_wait", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("r_req_async", 32'(mem_req), 32'd0);
    chk("r_ready_async", 32'({if_ready, dm_ready}), 32'd0);
    chk("r_err_async", 32'(err), 32'd0);
    dm_req = 0;
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | if_ready | dm_ready | mem_req;
    end
    chk("r_no_pulse", 32'(seen), 32'd0);

    // ack in the final timeout cycle wins
    ack_en = 1; ack_delay = 7; ack_data = 32'h0000_1234;
    dm_req = 1; dm_we = 0; dm_addr = 32'h88;
    wait_rdy(n, wi);
    chk("a_latency", 32'(n), 32'd9);
    chk("a_owner", 32'(wi), 32'd0);
    chk("a_rdata", dm_rdata, 32'h0000_1234);
    chk("a_err", 32'(err), 32'd0);
    dm_req = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
